// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD/MMC framing constants
package sd_pkg;

  localparam int         CRC7_W    = 7;
  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam logic [6:0] CRC7_INIT = 7'h00;

endpackage

// File: rtl/crc7_step.sv
// rtl/crc7_step.sv - one-bit MSB-first CRC next-state function
module crc7_step
  import sd_pkg::*;
#(
  parameter int               CRC_W = CRC7_W,
  parameter logic [CRC_W-1:0] POLY  = CRC7_POLY
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc_out
);

  logic fb;

  // x^CRC_W is implicit: the bit shifted out of the MSB becomes the feedback.
  assign fb      = bit_in ^ crc_in[CRC_W-1];
  assign crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ ({CRC_W{fb}} & POLY);

endmodule

// File: rtl/crc7_serial.sv
// rtl/crc7_serial.sv - bit-serial CRC-7 generator/checker for SD command frames
module crc7_serial
  import sd_pkg::*;
#(
  parameter int               CRC_W = CRC7_W,
  parameter logic [CRC_W-1:0] POLY  = CRC7_POLY,
  parameter logic [CRC_W-1:0] INIT  = CRC7_INIT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BITVAL,
  input  logic             Enable,
  output logic [CRC_W-1:0] CRC
);

  logic [CRC_W-1:0] crc_next;

  crc7_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_step (
    .crc_in  (CRC),
    .bit_in  (BITVAL),
    .crc_out (crc_next)
  );

  // BITVAL only reaches the register through the Enable-qualified path,
  // so an undriven bit during idle cycles cannot disturb the remainder.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CRC <= INIT;
    end else if (Enable) begin
      CRC <= crc_next;
    end
  end

endmodule

// File: tb/tb_crc7_serial.sv
// tb/tb_crc7_serial.sv - directed self-checking bench for crc7_serial
module tb_crc7_serial;

  logic       clk;
  logic       rst_n;
  logic       bitval;
  logic       enable;
  logic [6:0] crc;

  int total = 0;
  int bad   = 0;

  crc7_serial dut (
    .CLK    (clk),
    .RST    (rst_n),
    .BITVAL (bitval),
    .Enable (enable),
    .CRC    (crc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, got, exp);
    end
  endtask

  // Drive bits [39:39-n+1] of a frame MSB first, one per cycle.
  task automatic send_bits(input logic [39:0] frame, input int n);
    for (int i = 39; i > 39 - n; i--) begin
      @(negedge clk);
      bitval = frame[i];
      enable = 1'b1;
    end
    @(negedge clk);
    enable = 1'b0;
    bitval = 1'($urandom);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  logic [39:0] cmd0, cmd17, cmd8;
  logic [6:0]  held;

  initial begin
    cmd0   = {8'h40, 32'h0000_0000};
    cmd17  = {8'h51, 32'h0000_0000};
    cmd8   = {8'h48, 32'h0000_01AA};
    rst_n  = 1'b0;
    bitval = 1'b0;
    enable = 1'b0;

    // Reset holds INIT regardless of clock and inputs
    #1 check("reset_async", crc, 7'h00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bitval = 1'($urandom);
      enable = 1'($urandom);
      #1 check("reset_hold", crc, 7'h00);
    end
    @(negedge clk);
    enable = 1'b1;
    bitval = 1'b1;
    @(negedge clk);
    check("reset_clk_en", crc, 7'h00);
    enable = 1'b0;
    #2 rst_n = 1'b1;

    send_bits(cmd0, 40);
    check("cmd0", crc, 7'h4A);

    reset_pulse();
    send_bits(cmd17, 40);
    check("cmd17", crc, 7'h2A);

    reset_pulse();
    send_bits(cmd8, 40);
    check("cmd8", crc, 7'h43);

    // CMD0 with idle gaps inserted before three bit positions
    reset_pulse();
    for (int i = 39; i >= 0; i--) begin
      if (i == 33 || i == 20 || i == 6) begin
        int gap;
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          enable = 1'b0;
          bitval = 1'($urandom);
        end
      end
      @(negedge clk);
      bitval = cmd0[i];
      enable = 1'b1;
    end
    @(negedge clk);
    enable = 1'b0;
    check("cmd0_gaps", crc, 7'h4A);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bitval = ~bitval;
      check("idle_stable", crc, 7'h4A);
    end

    // Abort CMD17 mid-frame with an asynchronous reset between edges
    reset_pulse();
    for (int i = 39; i > 19; i--) begin
      @(negedge clk);
      bitval = cmd17[i];
      enable = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1 check("abort_async", crc, 7'h00);
    enable = 1'b0;
    #1 rst_n = 1'b1;
    send_bits(cmd0, 40);
    check("cmd0_after_abort", crc, 7'h4A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
